// File: rtl/pkt_rr_sched_pkg.sv
// rtl/pkt_rr_sched_pkg.sv - shared types and constants for the packet round-robin scheduler
package pkt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TERM = 2'd2
  } sched_state_e;

  // Empty-byte count carried by the synthetic terminating beat of an aborted packet
  localparam logic [63:0] TERM_MTY = '1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_rr_sched_if.sv
// rtl/pkt_rr_sched_if.sv - per-port ingress streams plus the shared egress stream
interface pkt_rr_sched_if #(
  parameter int C_NUM_PORTS  = 4,
  parameter int C_DATA_WIDTH = 8,
  parameter int C_MTY_WIDTH  = 8
);

  logic [C_NUM_PORTS-1:0]              s_axis_tvalid;
  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0] s_axis_tdata;
  logic [C_NUM_PORTS-1:0]              s_axis_tlast;
  logic [C_NUM_PORTS*C_MTY_WIDTH-1:0]  s_axis_tuser_mty;
  logic [C_NUM_PORTS-1:0]              s_axis_tready;

  logic                                m_axis_tvalid;
  logic [C_DATA_WIDTH-1:0]             m_axis_tdata;
  logic                                m_axis_tlast;
  logic [C_MTY_WIDTH-1:0]              m_axis_tuser_mty;
  logic                                m_axis_tready;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser_mty, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser_mty
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser_mty, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser_mty
  );

endinterface

// File: rtl/pkt_rr_sched_rr_pick.sv
// rtl/pkt_rr_sched_rr_pick.sv - rotating priority encoder: first set request at or after ptr, modulo N
module rr_pick
  import pkt_sched_pkg::*;
#(
  parameter  int C_NUM_PORTS = 4,
  localparam int IW          = idx_width(C_NUM_PORTS)
) (
  input  logic [C_NUM_PORTS-1:0] req_i,
  input  logic [IW-1:0]          ptr_i,
  output logic                   any_o,
  output logic [IW-1:0]          idx_o
);

  int p;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    p     = 0;
    for (int i = 0; i < C_NUM_PORTS; i++) begin
      p = (int'(ptr_i) + i) % C_NUM_PORTS;
      if (!any_o && req_i[p]) begin
        any_o = 1'b1;
        idx_o = IW'(p);
      end
    end
  end

endmodule

// File: rtl/pkt_rr_sched.sv
// rtl/pkt_rr_sched.sv - packet-granular round-robin scheduler onto one egress stream
// Optional mid-packet stall timeout with synthetic packet termination: PKT_SCHED_TIMEOUT_EN
module pkt_rr_sched
  import pkt_sched_pkg::*;
#(
  parameter  int C_NUM_PORTS      = 4,
  parameter  int C_DATA_WIDTH     = 8,
  parameter  int C_MTY_WIDTH      = 8,
  parameter  int C_TIMEOUT_CYCLES = 256,
  localparam int IW               = idx_width(C_NUM_PORTS)
) (
  input  logic                   aclk,
  input  logic                   areset,
  pkt_rr_sched_if.slave          axis,
  output logic [C_NUM_PORTS-1:0] drop_incmpt_pkt,
  output logic [IW-1:0]          grant_id,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_XFER = XFER;

  if (C_NUM_PORTS < 2 || C_NUM_PORTS > 16 || C_TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("pkt_rr_sched: unsupported parameter set");
  end

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          g_valid;
  logic          beat_acc;

  rr_pick #(.C_NUM_PORTS(C_NUM_PORTS)) u_pick (
    .req_i (axis.s_axis_tvalid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign g_valid  = axis.s_axis_tvalid[grant_q];
  assign beat_acc = axis.m_axis_tvalid & axis.m_axis_tready;
  assign next_ptr = (grant_q == IW'(C_NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

`ifdef PKT_SCHED_TIMEOUT_EN
  localparam logic [1:0] S_TERM = TERM;
  localparam int         CW     = idx_width(C_TIMEOUT_CYCLES);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [C_NUM_PORTS-1:0] drop_q, drop_d;

  assign drop_incmpt_pkt = drop_q;
`else
  assign drop_incmpt_pkt = '0;
`endif

  // Egress is a pure pass-through of the granted port; no beat moves while arbitrating
  always_comb begin
    axis.m_axis_tvalid    = 1'b0;
    axis.m_axis_tdata     = '0;
    axis.m_axis_tlast     = 1'b0;
    axis.m_axis_tuser_mty = '0;
    axis.s_axis_tready    = '0;
    case (state_q)
      S_XFER: begin
        axis.m_axis_tvalid          = g_valid;
        axis.m_axis_tdata           = axis.s_axis_tdata[grant_q*C_DATA_WIDTH +: C_DATA_WIDTH];
        axis.m_axis_tlast           = axis.s_axis_tlast[grant_q];
        axis.m_axis_tuser_mty       = axis.s_axis_tuser_mty[grant_q*C_MTY_WIDTH +: C_MTY_WIDTH];
        axis.s_axis_tready[grant_q] = axis.m_axis_tready;
      end
`ifdef PKT_SCHED_TIMEOUT_EN
      S_TERM: begin
        axis.m_axis_tvalid    = 1'b1;
        axis.m_axis_tlast     = 1'b1;
        axis.m_axis_tuser_mty = TERM_MTY[C_MTY_WIDTH-1:0];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
`ifdef PKT_SCHED_TIMEOUT_EN
    cnt_d    = cnt_q;
    drop_d   = '0;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef PKT_SCHED_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (beat_acc && axis.m_axis_tlast) begin
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end
`ifdef PKT_SCHED_TIMEOUT_EN
        else if (g_valid) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(C_TIMEOUT_CYCLES - 1)) begin
          cnt_d           = '0;
          drop_d[grant_q] = 1'b1;
          state_d         = S_TERM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
`ifdef PKT_SCHED_TIMEOUT_EN
      S_TERM: begin
        if (axis.m_axis_tready) begin
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
`ifdef PKT_SCHED_TIMEOUT_EN
      cnt_q    <= '0;
      drop_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef PKT_SCHED_TIMEOUT_EN
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
`endif
    end
  end

endmodule
